// File: rtl/led_scanner_if.sv
// ---------------------------------------------------------------------------
// led_scanner_if
// Groups the control inputs, the LED/step outputs and the debug view of the
// scanner state into one bundle. Clock and reset stay plain module ports.
//
// Handshake: there is no valid/ready pair here. enable_i is a level that gates
// the step prescaler. mode_i is sampled only on a step tick. led_display_o and
// step_o are registered outputs and are valid every cycle.
//
// Signals
//   enable_i      master->slave  1 = run, 0 = freeze pattern
//   mode_i        master->slave  0 bounce, 1 rotate, 2 bar, 3 blink
//   led_display_o slave->master  LED drive (polarity applied)
//   step_o        slave->master  one-cycle pulse per pattern step
//   dbg_pos       slave->master  current head index / bar count
//   dbg_dir       slave->master  scan direction state (0 up, 1 down)
//   dbg_mode      slave->master  captured mode
// ---------------------------------------------------------------------------
interface led_scanner_if #(
  parameter int NUM_LEDS = 8,
  parameter int POS_W    = $clog2(NUM_LEDS + 1)
);
  logic                enable_i;
  logic [1:0]          mode_i;
  logic [NUM_LEDS-1:0] led_display_o;
  logic                step_o;
  logic [POS_W-1:0]    dbg_pos;
  logic                dbg_dir;
  logic [1:0]          dbg_mode;

  modport master (
    output enable_i, mode_i,
    input  led_display_o, step_o, dbg_pos, dbg_dir, dbg_mode
  );

  modport slave (
    input  enable_i, mode_i,
    output led_display_o, step_o, dbg_pos, dbg_dir, dbg_mode
  );
endinterface

// File: rtl/led_scanner.sv
// ---------------------------------------------------------------------------
// led_scanner
// LED pattern generator for board bring-up: bounce scanner with optional
// fading tail, rotate, bar-graph fill/drain and all-blink. Each LED has an
// intensity level that is turned into a duty cycle by a free-running PWM
// counter.
//
// Ports
//   clk_i   system clock
//   rstn_i  asynchronous, active-low reset
//   bus     led_scanner_if.slave (enable_i, mode_i, led_display_o, step_o,
//           debug state)
// ---------------------------------------------------------------------------
module led_scanner #(
  parameter int   CLK_IN_MHZ     = 125,
  parameter int   NUM_LEDS       = 8,
  parameter logic LED_POLARITY   = 1'b0,
  parameter int   SWEEPS_PER_SEC = 1,
  parameter logic TRAIL_EN       = 1'b1,
  parameter int   PWM_BITS       = 4,
  parameter logic FAST_SIM       = 1'b0
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  led_scanner_if.slave  bus
);

  // One full bounce is 2*(N-1) steps, so this divider gives SWEEPS_PER_SEC
  // bounces per second.
  localparam int STEP_DIV_RAW = (CLK_IN_MHZ * 1000000) / (SWEEPS_PER_SEC * 2 * (NUM_LEDS - 1));
  localparam int STEP_DIV     = (STEP_DIV_RAW < 1) ? 1 : STEP_DIV_RAW;
  localparam int PRESC_W      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int POS_W        = $clog2(NUM_LEDS + 1);

  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0]    LAST_IDX  = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]    BAR_MAX   = POS_W'(NUM_LEDS);
  localparam logic [PWM_BITS-1:0] FULL      = '1;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [PRESC_W-1:0]                r_presc;
  logic                              w_tick;
  logic                              r_step;
  logic [POS_W-1:0]                  r_pos, w_pos_n;
  dir_t                              r_dir, w_dir_n;
  logic [1:0]                        r_mode, w_mode_n;
  logic                              r_phase, w_phase_n;
  logic                              r_primed;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] r_level, w_level_n;
  logic [PWM_BITS-1:0]               r_pwm_cnt;
  logic [NUM_LEDS-1:0]               w_on;
  logic [NUM_LEDS-1:0]               r_led;

  // Step prescaler: only advances while enabled, so a pause delays the next
  // step by exactly the paused cycles.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_presc <= '0;
    end else if (bus.enable_i) begin
      r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
    end
  end

  assign w_tick = FAST_SIM ? bus.enable_i : (bus.enable_i && (r_presc == PRESC_MAX));

  // Pattern state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pos    <= '0;
      r_dir    <= DIR_UP;
      r_mode   <= 2'd0;
      r_phase  <= 1'b0;
      r_primed <= 1'b0;
      r_level  <= '0;
    end else begin
      r_pos    <= w_pos_n;
      r_dir    <= w_dir_n;
      r_mode   <= w_mode_n;
      r_phase  <= w_phase_n;
      r_primed <= r_primed | w_tick;
      r_level  <= w_level_n;
    end
  end

  // Next-state logic. The first tick after reset is handled like a mode
  // capture so the head appears at LED 0 instead of advancing past it.
  always_comb begin
    w_pos_n   = r_pos;
    w_dir_n   = r_dir;
    w_mode_n  = r_mode;
    w_phase_n = r_phase;
    w_level_n = r_level;
    if (w_tick) begin
      if (!r_primed || (bus.mode_i != r_mode)) begin
        w_mode_n  = bus.mode_i;
        w_pos_n   = '0;
        w_dir_n   = DIR_UP;
        w_phase_n = 1'b0;
        w_level_n = '0;
        // Bar count 0 and blink phase 0 are both dark; only the scanning
        // modes show a head at index 0.
        if (!bus.mode_i[1]) w_level_n[0] = FULL;
      end else begin
        case (r_mode)
          2'd0: begin
            if (r_dir == DIR_UP) begin
              w_pos_n = r_pos + 1'b1;
              if (w_pos_n == LAST_IDX) w_dir_n = DIR_DOWN;
            end else begin
              w_pos_n = r_pos - 1'b1;
              if (w_pos_n == '0) w_dir_n = DIR_UP;
            end
          end
          2'd1: w_pos_n = (r_pos == LAST_IDX) ? '0 : r_pos + 1'b1;
          2'd2: begin
            if (r_dir == DIR_UP) begin
              w_pos_n = r_pos + 1'b1;
              if (w_pos_n == BAR_MAX) w_dir_n = DIR_DOWN;
            end else begin
              w_pos_n = r_pos - 1'b1;
              if (w_pos_n == '0) w_dir_n = DIR_UP;
            end
          end
          default: w_phase_n = ~r_phase;
        endcase

        for (int i = 0; i < NUM_LEDS; i++) begin
          case (r_mode)
            2'd0, 2'd1: w_level_n[i] = (w_pos_n == POS_W'(i)) ? FULL :
                                       (TRAIL_EN ? (r_level[i] >> 1) : '0);
            2'd2:       w_level_n[i] = (POS_W'(i) < w_pos_n) ? FULL : '0;
            default:    w_level_n[i] = w_phase_n ? FULL : '0;
          endcase
        end
      end
    end
  end

  // PWM: a level L is on for L of every 2^PWM_BITS cycles.
  always_comb begin
    w_on = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      w_on[i] = (r_level[i] > r_pwm_cnt);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pwm_cnt <= '0;
      r_led     <= {NUM_LEDS{~LED_POLARITY}};
      r_step    <= 1'b0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_led     <= LED_POLARITY ? w_on : ~w_on;
      r_step    <= w_tick;
    end
  end

  assign bus.led_display_o = r_led;
  assign bus.step_o        = r_step;
  assign bus.dbg_pos       = r_pos;
  assign bus.dbg_dir       = r_dir;
  assign bus.dbg_mode      = r_mode;

endmodule
